// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: pipeline writes win, MDU results queue in order.
// Optional stall counter output enabled by defining REGFILE_WB_STALL_CNT_EN.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    input  logic [4:0]  q_addr,
    output logic        q_pending
`ifdef REGFILE_WB_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0]       r_vld;
    logic [DEPTH-1:0][4:0]  r_addr;
    logic [DEPTH-1:0][31:0] r_data;
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [CW-1:0]          r_count;
    logic                   r_wb_we;
    logic [4:0]             r_wb_addr;
    logic [31:0]            r_wb_data;

    logic          w_pipe_wr;
    logic          w_found;
    logic [CW-1:0] w_off;
    logic [AW-1:0] w_head;
    logic          w_pop;
    logic          w_acc;
    logic          w_push;
    logic [CW-1:0] w_drop;
    logic          w_pend;

    assign w_pipe_wr = pipe_valid && (pipe_addr != 5'd0);
    assign mdu_ready = (r_count < CW'(DEPTH));
    assign w_acc     = mdu_valid && mdu_ready;
    // A same-edge pipeline write to the same register is younger, so the result is dead on arrival.
    assign w_push    = w_acc && (mdu_addr != 5'd0) && !(w_pipe_wr && (mdu_addr == pipe_addr));

    // Oldest live entry; invalidated entries ahead of it are dropped on this edge.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        w_head  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_found && (CW'(i) < r_count) && r_vld[AW'(r_rptr + AW'(i))]) begin
                w_found = 1'b1;
                w_off   = CW'(i);
                w_head  = AW'(r_rptr + AW'(i));
            end
        end
    end

    assign w_pop  = w_found && !w_pipe_wr;
    assign w_drop = w_found ? (w_off + CW'(w_pop)) : r_count;

    always_comb begin
        w_pend = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i] == q_addr)) w_pend = 1'b1;
        end
    end
    assign q_pending = w_pend && (q_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld     <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_wb_we   <= 1'b0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pipe_wr && r_vld[i] && (r_addr[i] == pipe_addr)) r_vld[i] <= 1'b0;
                if (w_pop && (AW'(i) == w_head)) r_vld[i] <= 1'b0;
                if (w_push && (AW'(i) == r_wptr)) r_vld[i] <= 1'b1;
            end
            if (w_push) r_wptr <= r_wptr + 1'b1;
            r_rptr  <= r_rptr + AW'(w_drop);
            r_count <= r_count + CW'(w_push) - w_drop;

            if (w_pipe_wr) begin
                r_wb_we   <= 1'b1;
                r_wb_addr <= pipe_addr;
                r_wb_data <= pipe_data;
            end else if (w_found) begin
                r_wb_we   <= 1'b1;
                r_wb_addr <= r_addr[w_head];
                r_wb_data <= r_data[w_head];
            end else begin
                r_wb_we   <= 1'b0;
            end
        end
    end

    // Payload needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wptr] <= mdu_addr;
            r_data[r_wptr] <= mdu_data;
        end
    end

    assign wb_we   = r_wb_we;
    assign wb_addr = r_wb_addr;
    assign wb_data = r_wb_data;

`ifdef REGFILE_WB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_found && w_pipe_wr && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning MDU result queue entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port pipe_valid  input  1  main-pipeline writeback request, always accepted.
REQ-005 SHALL have port pipe_addr  input  5  destination register of the pipeline write.
REQ-006 SHALL have port pipe_data  input  32  pipeline write data.
REQ-007 SHALL have port mdu_valid  input  1  multi-cycle unit result offered.
REQ-008 SHALL have port mdu_ready  output  1  queue can accept; equals not full, registered state only.
REQ-009 SHALL have port mdu_addr  input  5  destination register of the MDU result.
REQ-010 SHALL have port mdu_data  input  32  MDU result data.
REQ-011 SHALL have port wb_we  output  1  register-file write enable, registered.
REQ-012 SHALL have port wb_addr  output  5  register-file write address, registered.
REQ-013 SHALL have port wb_data  output  32  register-file write data, registered.
REQ-014 SHALL have port q_addr  input  5  hazard-unit query address.
REQ-015 SHALL have port q_pending  output  1  combinational; 1 if any valid queued entry targets q_addr (q_addr 0 gives 0).

Function
REQ-016 SHALL accept an MDU result on a posedge where mdu_valid and mdu_ready are both 1; results to address 0 are accepted and discarded.
REQ-017 SHALL, each posedge, load the wb outputs from pipe_* if pipe_valid and pipe_addr is nonzero, otherwise from the oldest valid queue entry, popping it; with neither, wb_we = 0 and wb_addr/wb_data hold.
REQ-018 SHALL give pipeline writes 1-cycle latency: request on posedge N, wb_we high after posedge N.
REQ-019 SHALL make an MDU entry accepted on posedge N eligible no earlier than posedge N+1 (no same-edge bypass).
REQ-020 SHALL write back queued entries in acceptance order.
REQ-021 SHALL, on a pipeline write to nonzero address X, invalidate every queued entry targeting X in the same edge; the pipeline write is younger by construction.
REQ-022 SHALL handle an invalidated entry at the queue head by skipping it without producing a write, so the next valid entry writes in the same cycle.
REQ-023 SHALL never assert wb_we with wb_addr = 0; a pipeline write to address 0 is dropped and does not block a queue pop.
REQ-024 SHALL keep occupancy in a log2(DEPTH)+1-bit count with wrapping read/write pointers; a simultaneous push and pop leaves the count unchanged.
REQ-025 SHALL assert mdu_ready only when occupancy < DEPTH; when full, ready stays 0 even on a popping cycle.
REQ-026 SHALL present outputs stable from posedge through the following negedge, when the register file commits.

Reset
REQ-027 SHALL, on reset high at posedge, clear the queue (count, pointers, valid bits) and drive wb_we = 0, wb_addr = 0, wb_data = 0, mdu_ready = 1 after that edge.
REQ-028 SHALL ignore pipe_valid and mdu_valid on a reset edge; entries in flight are lost.

Configuration
REQ-029 SHALL, with macro REGFILE_WB_STALL_CNT_EN defined, add output stall_cnt (16 bits): +1 each posedge where a valid queue entry is held back by a pipeline write, saturating at 0xFFFF, cleared by reset.
REQ-030 SHALL, without REGFILE_WB_STALL_CNT_EN, omit stall_cnt and its logic entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: pipe write addr 5, data 0xDEADBEEF -> wb_we=1, wb_addr=5, wb_data=0xDEADBEEF after the next posedge.
REQ-032 SHALL cover: 4 MDU pushes (addr 1..4) with pipe_valid held 1 to addr 9 -> mdu_ready=0 after the 4th push; after pipe_valid drops, writes to 1,2,3,4 in order.
REQ-033 SHALL cover: queue holds addr 7 then 8; pipe writes addr 7 -> q_pending(7)=0; next writes are 7 (pipe data), then 8 only.
REQ-034 SHALL cover: pipe write addr 0 and MDU push addr 0 -> wb_we never asserted, queue stays empty.
REQ-035 SHALL cover: reset asserted with 3 entries queued -> wb_we=0, mdu_ready=1, q_pending=0 for all addresses after the edge.
REQ-036 SHALL cover (REGFILE_WB_STALL_CNT_EN): 3 cycles of pipe priority over a nonempty queue -> stall_cnt=3.
